i2c_cmd_queue: RTL
==================

Name: i2c_cmd_queue

Overview:
Command front end that sits directly upstream of the I2C master controller.
- Buffers write/read transaction requests from the host in a small FIFO.
- Issues them to the master one at a time and holds the master's operands stable for the whole transfer.
- Tracks completion through the master's free flag and flags timeouts.

Parameters:
ADDR_LEN, 7, slave address width
DATA_LEN, 8, data byte width
DEPTH, 4, FIFO entries; power of two, >=2
START_TIMEOUT, 16, cycles allowed for free to fall after start is raised
XFER_TIMEOUT, 1023, cycles allowed in one transfer before a hang is flagged
TMO_W, 10, counter width; must hold max(START_TIMEOUT, XFER_TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  queue can accept a command
cmd_addr  in  ADDR_LEN  slave address
cmd_rw  in  1  1=read, 0=write
cmd_data1  in  DATA_LEN  first data byte
cmd_data2  in  DATA_LEN  second data byte
cmd_ack3p  in  1  third-phase ack value
flush  in  1  synchronous clear of queued (not in-flight) commands
free  in  1  master idle flag
state_master  in  4  master state, for error capture
start  out  1  launch request to master
add_reg  out  ADDR_LEN  held address
R_W  out  1  held direction
data_1  out  DATA_LEN  held byte 1
data_2  out  DATA_LEN  held byte 2
ack_3p  out  1  held ack value
busy  out  1  transfer in flight
done  out  1  one-cycle pulse on transfer completion
err  out  1  one-cycle pulse on timeout
err_code  out  2  01=start timeout, 10=transfer timeout; held until next err
err_state  out  4  state_master captured at err
level  out  clog2(DEPTH)+1  queued entry count

Behaviour:
- Reset, asynchronous and active-high: all outputs 0 except cmd_ready=1. FIFO is empty and the FSM is in IDLE.
- FIFO:
  - Push occurs when cmd_valid & cmd_ready.
  - cmd_ready = !full, registered from level. A pop in the same cycle does not raise cmd_ready.
  - Read and write pointers carry one wrap bit; they wrap modulo DEPTH.
  - No fall-through: an entry pushed in cycle N is poppable from N+1.
  - flush sets the pointers equal and level to 0 next cycle. If flush and a push occur together, flush wins and the push is dropped. flush has no effect on the FSM or on the held operands.
- FSM states: IDLE, LAUNCH, WAIT_FREE.
- IDLE:
  - When !empty & free=1: pop, register all operands onto the master outputs, and go to LAUNCH. busy=1 from the next cycle.
  - Latency: a command pushed into an empty queue in cycle N gives start=1 in cycle N+2.
- LAUNCH:
  - start=1, and the timeout counter counts.
  - If free=0: start=0 next cycle, clear the counter, go to WAIT_FREE.
  - If START_TIMEOUT cycles elapse with free=1: start=0, err pulse, err_code=01, err_state captured, busy=0, go to IDLE. The command is dropped.
- WAIT_FREE:
  - When free=1: done pulse, busy=0, go to IDLE.
  - The next command may launch the cycle after done.
  - If the counter reaches XFER_TIMEOUT: err pulse, err_code=10, err_state captured. The FSM keeps waiting; the counter saturates, so err fires once per transfer.
- Operand hold: add_reg, R_W, data_1, data_2, ack_3p change only on an IDLE pop. They are stable from LAUNCH until the next pop.
- Master not idle: free=0 while in IDLE (master busy from another source) blocks launch; nothing is popped.
- Reset mid-transfer: all outputs return to reset values immediately and the queue is emptied.
- done and err are never both high in the same cycle.

Decomposition:
- Shared package holds:
  - FSM state encoding (2 bits).
  - err_code constants ERR_NONE, ERR_START, ERR_XFER.
  - Command record width ADDR_LEN+1+2*DATA_LEN+1 and its field offsets.
- One sub-module, i2c_cmd_fifo:
  - Parameterised on width and DEPTH.
  - Provides push/pop/flush, full/empty and level.
- The top level holds the FSM, timeout counter, operand registers and error capture.

Test Plan:
- Single write: push addr=7'h50, rw=0, d1=8'hA5, d2=8'h3C in cycle 0 with free=1; free drops in cycle 3 and rises in cycle 40 -> start=1 in cycles 2-3; outputs hold 50/0/A5/3C; done pulses in cycle 41; busy is 1 from cycle 2 through 40, 0 in cycle 41.
- Fill: push 5 commands back-to-back with DEPTH=4 and free held 0 -> cmd_ready=0 after the 4th; the 5th is not accepted; level=4.
- Drain order: 3 queued commands each completed by the bench -> three done pulses; add_reg sequence matches push order; level goes 3 through 0.
- Start timeout: free held 1 forever -> start high for 16 cycles; err pulses; err_code=01; err_state equals state_master; the next command launches afterward.
- Transfer hang: free drops and never rises -> exactly one err, after 1023 cycles, with err_code=10; the FSM stays in WAIT_FREE.
- Flush plus reset: 3 queued and one in flight, then flush -> level=0 while the in-flight transfer still gives done. A further test asserts rst mid-LAUNCH -> start=0 asynchronously; cmd_ready=1 after release.

Source files
------------

// File: rtl/i2c_cmd_queue_pkg.sv
// Shared definitions for the I2C command queue: FSM encoding, error codes
// and the packed command record layout.
package i2c_cmd_queue_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_FREE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_XFER  = 2'b10;

    // Record layout, LSB first: addr | rw | data1 | data2 | ack3p
    function automatic int cmd_width(input int addr_len, input int data_len);
        return addr_len + 1 + 2 * data_len + 1;
    endfunction

    function automatic int off_rw(input int addr_len);
        return addr_len;
    endfunction

    function automatic int off_d1(input int addr_len);
        return addr_len + 1;
    endfunction

    function automatic int off_d2(input int addr_len, input int data_len);
        return addr_len + 1 + data_len;
    endfunction

    function automatic int off_ack(input int addr_len, input int data_len);
        return addr_len + 1 + 2 * data_len;
    endfunction

endpackage

// File: rtl/i2c_cmd_queue_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; no fall-through, flush
// drops everything queued and wins over a simultaneous push.
module i2c_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/i2c_cmd_queue.sv
// Command front end for the I2C master: queues host requests, launches them
// one at a time with held operands, and flags start/transfer timeouts.
//
// state     | meaning
// IDLE      | waiting for a queued command and a free master
// LAUNCH    | start raised, waiting for master to drop free
// WAIT_FREE | transfer in flight, waiting for free to return
module i2c_cmd_queue
    import i2c_cmd_queue_pkg::*;
#(
    parameter int ADDR_LEN      = 7,
    parameter int DATA_LEN      = 8,
    parameter int DEPTH         = 4,
    parameter int START_TIMEOUT = 16,
    parameter int XFER_TIMEOUT  = 1023,
    parameter int TMO_W         = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_LEN-1:0]       cmd_addr,
    input  logic                      cmd_rw,
    input  logic [DATA_LEN-1:0]       cmd_data1,
    input  logic [DATA_LEN-1:0]       cmd_data2,
    input  logic                      cmd_ack3p,
    input  logic                      flush,
    input  logic                      free,
    input  logic [3:0]                state_master,
    output logic                      start,
    output logic [ADDR_LEN-1:0]       add_reg,
    output logic                      R_W,
    output logic [DATA_LEN-1:0]       data_1,
    output logic [DATA_LEN-1:0]       data_2,
    output logic                      ack_3p,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [3:0]                err_state,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int CW = cmd_width(ADDR_LEN, DATA_LEN);

    state_t            state, state_n;
    logic [TMO_W-1:0]  cnt;
    logic              cnt_clr, cnt_inc;
    logic              pop, full, empty;
    logic              done_n, err_n;
    logic [1:0]        err_code_n;
    logic [CW-1:0]     head;

    i2c_cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .flush (flush),
        .wdata ({cmd_ack3p, cmd_data2, cmd_data1, cmd_rw, cmd_addr}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign cmd_ready = !full;
    assign start     = (state == LAUNCH);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        err_code_n = ERR_NONE;
        unique case (state)
            IDLE: begin
                // A flushing queue is not popped, so nothing stale launches.
                if (!empty && free && !flush) begin
                    pop     = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!free) begin
                    cnt_clr = 1'b1;
                    state_n = WAIT_FREE;
                end else if (cnt == TMO_W'(START_TIMEOUT - 1)) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_START;
                    state_n    = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_FREE: begin
                if (free) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    if (cnt == TMO_W'(XFER_TIMEOUT - 1)) begin
                        err_n      = 1'b1;
                        err_code_n = ERR_XFER;
                    end
                    // Saturating keeps the hang error to one pulse per transfer.
                    if (cnt != TMO_W'(XFER_TIMEOUT)) cnt_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            add_reg   <= '0;
            R_W       <= 1'b0;
            data_1    <= '0;
            data_2    <= '0;
            ack_3p    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_state <= '0;
        end else begin
            state <= state_n;
            done  <= done_n;
            err   <= err_n;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + TMO_W'(1);
            if (err_n) begin
                err_code  <= err_code_n;
                err_state <= state_master;
            end
            if (pop) begin
                add_reg <= head[0 +: ADDR_LEN];
                R_W     <= head[off_rw(ADDR_LEN)];
                data_1  <= head[off_d1(ADDR_LEN) +: DATA_LEN];
                data_2  <= head[off_d2(ADDR_LEN, DATA_LEN) +: DATA_LEN];
                ack_3p  <= head[off_ack(ADDR_LEN, DATA_LEN)];
            end
        end
    end

endmodule
